mac_pipe: RTL and testbench

Pipelined signed fixed-point multiply-accumulate unit for the LSTM gate datapath. It accepts one (activation, weight) pair per cycle over a valid/ready handshake and sums VEC_LEN products plus a bias into a wide accumulator. Each completed dot product is rounded, rescaled and saturated, then returned as one output word per vector. It generalises the standalone combinational multiplier and 28-bit adder into a parametrised, back-pressured, streaming block.

---
 rtl/mac_pipe.sv | 174 +++++++++++++++++
 tb/tb_mac_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe.sv
// ---------------------------------------------------------------------------
// mac_pipe
// Streaming signed fixed-point multiply-accumulate for the LSTM gate datapath.
// Accepts one (activation, weight) term per cycle. VEC_LEN products plus a
// bias are summed into a wide accumulator. Each finished dot product is
// rounded half-up back to the input Q format and saturated. It is then held
// in a single-entry output register until the consumer takes it.
//
// Pipeline: S1 = registered product, S2 = accumulator, S3 = round/saturate
// into the output register. A stalled output (out_valid && !out_ready)
// freezes every stage and the term counter.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   in_valid/ready   input handshake for one term
//   in_a, in_b       signed activation / weight (DATA_WIDTH, FRAC_BITS frac)
//   in_bias          signed bias, sampled with the first term of a vector
//   out_valid/ready  output handshake for one result
//   out_data         rounded, saturated dot product (same Q format as inputs)
//   out_sat          out_data was clipped
// ---------------------------------------------------------------------------
module mac_pipe #(
    parameter int DATA_WIDTH = 14,
    parameter int FRAC_BITS  = 10,
    parameter int VEC_LEN    = 16,
    parameter int ACC_WIDTH  = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    // Rounding constant and saturation limits in accumulator width
    localparam logic [ACC_WIDTH-1:0] HALF_LSB = ACC_WIDTH'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // State
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_first_q, s1_first_d;
    logic                         s1_last_q, s1_last_d;
    logic signed [PROD_W-1:0]     s1_prod_q, s1_prod_d;
    logic [DATA_WIDTH-1:0]        s1_bias_q, s1_bias_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         s2_done_q, s2_done_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
    logic                         out_sat_q, out_sat_d;

    // Combinational helpers
    logic                         stall;
    logic                         accept;
    logic signed [PROD_W-1:0]     prod_full;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  rnd_sum;
    logic signed [ACC_WIDTH-1:0]  rnd_shift;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !rst && !stall;
    assign accept   = in_valid && in_ready;

    // Operands are sign-extended to the full product width first. The
    // 2*DATA_WIDTH result is then exact, including min*min.
    assign prod_full = PROD_W'($signed(in_a)) * PROD_W'($signed(in_b));

    assign prod_ext = {{(ACC_WIDTH-PROD_W){s1_prod_q[PROD_W-1]}}, s1_prod_q};
    // The bias is in the input Q format. It is shifted up to the product's
    // 2*FRAC_BITS scale before it seeds the accumulator.
    assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){s1_bias_q[DATA_WIDTH-1]}},
                       s1_bias_q, {FRAC_BITS{1'b0}}};

    // Round half up, then drop the extra fractional bits arithmetically
    assign rnd_sum   = acc_q + $signed(HALF_LSB);
    assign rnd_shift = rnd_sum >>> FRAC_BITS;

    always_comb begin
        cnt_d       = cnt_q;
        s1_valid_d  = s1_valid_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_prod_d   = s1_prod_q;
        s1_bias_d   = s1_bias_q;
        acc_d       = acc_q;
        s2_done_d   = s2_done_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (!stall) begin
            // S1 / term counter
            s1_valid_d = accept;
            if (accept) begin
                s1_first_d = (cnt_q == '0);
                s1_last_d  = (cnt_q == LAST_CNT);
                s1_prod_d  = prod_full;
                s1_bias_d  = in_bias;
                cnt_d      = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
            end

            // S2: accumulate, seeding with the bias on the first term
            s2_done_d = s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                acc_d = s1_first_q ? (bias_ext + prod_ext) : (acc_q + prod_ext);
            end

            // S3: a finished vector loads the output register. The load
            // takes priority over clearing a result consumed in this cycle.
            if (s2_done_q) begin
                out_valid_d = 1'b1;
                if (rnd_shift > OUT_MAX) begin
                    out_data_d = OUT_MAX[DATA_WIDTH-1:0];
                    out_sat_d  = 1'b1;
                end else if (rnd_shift < OUT_MIN) begin
                    out_data_d = OUT_MIN[DATA_WIDTH-1:0];
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = rnd_shift[DATA_WIDTH-1:0];
                    out_sat_d  = 1'b0;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            s1_bias_q   <= '0;
            acc_q       <= '0;
            s2_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_prod_q   <= s1_prod_d;
            s1_bias_q   <= s1_bias_d;
            acc_q       <= acc_d;
            s2_done_q   <= s2_done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_mac_pipe
// Directed bench for mac_pipe. It uses two instances that share the data
// inputs, out_ready and rst:
//   u4 : VEC_LEN=4
//   u1 : VEC_LEN=1
// Inputs change on the falling edge. Outputs are read after the falling edge.
// Results taken by the consumer are queued and checked in order.
// ---------------------------------------------------------------------------
module tb_mac_pipe;
    localparam int DW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, out_ready;
    logic [DW-1:0] in_a, in_b, in_bias;
    logic          v4, r4, ov4, sat4;
    logic [DW-1:0] d4;
    logic          v1, r1, ov1, sat1;
    logic [DW-1:0] d1;

    int checks = 0;
    int errors = 0;

    logic [DW:0] q4[$];
    logic [DW:0] q1[$];

    mac_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(10), .VEC_LEN(4), .ACC_WIDTH(34)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
        .in_a(in_a), .in_b(in_b), .in_bias(in_bias),
        .out_valid(ov4), .out_ready(out_ready), .out_data(d4), .out_sat(sat4)
    );

    mac_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(10), .VEC_LEN(1), .ACC_WIDTH(34)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
        .in_a(in_a), .in_b(in_b), .in_bias(in_bias),
        .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_sat(sat1)
    );

    // Record every result handed over (valid && ready at the next rising edge)
    always @(negedge clk) begin
        #1;
        if (!rst && ov4 && out_ready) q4.push_back({sat4, d4});
        if (!rst && ov1 && out_ready) q1.push_back({sat1, d1});
    end

    function automatic logic [31:0] w14(input int v);
        logic [31:0] t;
        t = v;
        return {18'b0, t[13:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one term and hold it until accepted (bounded wait)
    task automatic send(input bit sel, input int a, input int b, input int bias);
        bit done;
        done    = 1'b0;
        in_a    = a[DW-1:0];
        in_b    = b[DW-1:0];
        in_bias = bias[DW-1:0];
        if (sel) v4 = 1'b1; else v1 = 1'b1;
        for (int n = 0; n < 60; n++) begin
            #1;
            if (sel ? r4 : r1) begin
                @(posedge clk);
                @(negedge clk);
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        v4 = 1'b0;
        v1 = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed=in_ready low expected=term accepted");
        end
        $display("term sel=%0d a=%0d b=%0d bias=%0d accepted=%0d", sel, a, b, bias, done);
    endtask

    // Wait (bounded) for the next queued result and compare it
    task automatic expect_res(input bit sel, input string tag, input int exp_d, input bit exp_s);
        logic [DW:0] e;
        bit got;
        got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (sel ? (q4.size() > 0) : (q1.size() > 0)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed=no result expected=data 0x%0h", tag, w14(exp_d));
        end else begin
            e = sel ? q4.pop_front() : q1.pop_front();
            $display("result %s data=0x%0h sat=%0d", tag, e[DW-1:0], e[DW]);
            chk({tag, "_data"}, {18'b0, e[DW-1:0]}, w14(exp_d));
            chk({tag, "_sat"}, {31'b0, e[DW]}, {31'b0, exp_s});
        end
    endtask

    initial begin
        int va[3];
        int vbias[3];
        int vexp[3];
        va    = '{1024, -1024, 512};
        vbias = '{0, 0, 100};
        vexp  = '{4096, -4096, 2148};

        rst = 1'b1; out_ready = 1'b1; v4 = 1'b0; v1 = 1'b0;
        in_a = '0; in_b = '0; in_bias = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'b0, ov4}, 32'd0);
        chk("rst_out_data",  {18'b0, d4},  32'd0);
        chk("rst_out_sat",   {31'b0, sat4}, 32'd0);
        chk("rst_in_ready",  {31'b0, r4},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready4", {31'b0, r4}, 32'd1);
        chk("post_rst_in_ready1", {31'b0, r1}, 32'd1);
        @(negedge clk);

        // T1: 4 x (1.0 * 0.5) = 2.0, with a latency of 3 cycles after the last term
        for (int t = 0; t < 4; t++) send(1'b1, 1024, 512, 0);
        chk("t1_lat_k1", {31'b0, ov4}, 32'd0);
        @(negedge clk);
        chk("t1_lat_k2", {31'b0, ov4}, 32'd0);
        @(negedge clk);
        chk("t1_lat_k3", {31'b0, ov4}, 32'd1);
        expect_res(1'b1, "t1", 2048, 1'b0);

        // T2: bias -1.0 plus 4 x (-1.0 * 0.5) = -3.0. The bias is ignored after the first term.
        send(1'b1, -1024, 512, -1024);
        for (int t = 1; t < 4; t++) send(1'b1, -1024, 512, 555);
        expect_res(1'b1, "t2", -3072, 1'b0);

        // T3: single-term vectors exercise rounding, bias and min*min
        send(1'b0, 1, 512, 0);        expect_res(1'b0, "t3_half_up", 1, 1'b0);
        send(1'b0, -1, 512, 0);       expect_res(1'b0, "t3_neg_half", 0, 1'b0);
        send(1'b0, -1, 513, 0);       expect_res(1'b0, "t3_neg_over", -1, 1'b0);
        send(1'b0, -8192, -8192, 0);  expect_res(1'b0, "t3_min_min", 8191, 1'b1);
        send(1'b0, 0, 100, 5);        expect_res(1'b0, "t3_bias_only", 5, 1'b0);

        // T4: positive and negative saturation
        for (int t = 0; t < 4; t++) send(1'b1, 8191, 8191, 0);
        expect_res(1'b1, "t4_pos_sat", 8191, 1'b1);
        for (int t = 0; t < 4; t++) send(1'b1, 8191, -8192, 0);
        expect_res(1'b1, "t4_neg_sat", -8192, 1'b1);

        // T5: three back-to-back vectors, with the consumer stalled for 10 cycles
        out_ready = 1'b0;
        fork
            begin
                for (int v = 0; v < 3; v++)
                    for (int t = 0; t < 4; t++)
                        send(1'b1, va[v], 1024, (t == 0) ? vbias[v] : 777);
            end
            begin
                bit seen;
                bit low_ready;
                seen = 1'b0;
                low_ready = 1'b0;
                for (int n = 0; n < 100; n++) begin
                    if (ov4) begin
                        seen = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                chk("t5_first_valid", {31'b0, seen}, 32'd1);
                for (int i = 0; i < 10; i++) begin
                    chk("t5_stall_data",  {18'b0, d4}, w14(4096));
                    chk("t5_stall_valid", {31'b0, ov4}, 32'd1);
                    if (!r4) low_ready = 1'b1;
                    @(negedge clk);
                end
                chk("t5_in_ready_dropped", {31'b0, low_ready}, 32'd1);
                out_ready = 1'b1;
            end
        join
        for (int v = 0; v < 3; v++) expect_res(1'b1, $sformatf("t5_v%0d", v), vexp[v], 1'b0);

        // T6: a partial vector is discarded by reset
        send(1'b1, 3072, 1024, 0);
        send(1'b1, 3072, 1024, 0);
        rst = 1'b1;
        #1;
        chk("t6_ready_in_rst", {31'b0, r4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_post_rst_valid", {31'b0, ov4}, 32'd0);
        chk("t6_post_rst_ready", {31'b0, r4}, 32'd1);
        for (int t = 0; t < 4; t++) send(1'b1, 1024, 1024, 0);
        expect_res(1'b1, "t6", 4096, 1'b0);
        repeat (10) @(negedge clk);
        chk("t6_no_extra_result", q4.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
